// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encoding and flag bit positions.
package alu_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      ADC = 3'b001,
      SUB = 3'b010,
      SBB = 3'b011,
      AND = 3'b100,
      OR  = 3'b101,
      XOR = 3'b110,
      CMP = 3'b111
   } alu_op_t;

   localparam int FLAG_C  = 0;
   localparam int FLAG_ZF = 1;
   localparam int FLAG_N  = 2;
   localparam int FLAG_V  = 3;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result and C/ZF/N/V flags for one operation.
// Overflow flag is only built when ALU_OVERFLOW_EN is defined.
module alu_comb
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   input  logic              cin,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        flags
);

   alu_op_t           op_e;
   logic              add_cin;
   logic              sub_cin;
   logic [DATA_W:0]   sum9;
   logic [DATA_W:0]   diff9;
   logic [DATA_W-1:0] flag_r;
   logic              carry;
   logic              v_flag;

   assign op_e = alu_op_t'(op);

   always_comb begin
      add_cin = (op_e == ADC) ? cin : 1'b0;
      sub_cin = (op_e == SBB) ? cin : 1'b0;
      sum9    = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, add_cin};
      // Bit 8 of the 9-bit difference is set exactly when A < B + Cin.
      diff9   = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, sub_cin};
   end

   always_comb begin
      result = '0;
      flag_r = '0;
      carry  = 1'b0;
      case (op_e)
         ADD, ADC: begin
            result = sum9[DATA_W-1:0];
            flag_r = sum9[DATA_W-1:0];
            carry  = sum9[DATA_W];
         end
         SUB, SBB: begin
            result = diff9[DATA_W-1:0];
            flag_r = diff9[DATA_W-1:0];
            carry  = diff9[DATA_W];
         end
         AND: begin
            result = a & b;
            flag_r = a & b;
         end
         OR: begin
            result = a | b;
            flag_r = a | b;
         end
         XOR: begin
            result = a ^ b;
            flag_r = a ^ b;
         end
         CMP: begin
            result = a;
            flag_r = diff9[DATA_W-1:0];
            carry  = diff9[DATA_W];
         end
         default: begin
            result = '0;
            flag_r = '0;
            carry  = 1'b0;
         end
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   always_comb begin
      v_flag = 1'b0;
      case (op_e)
         ADD, ADC:      v_flag = (a[DATA_W-1] == b[DATA_W-1]) && (flag_r[DATA_W-1] != a[DATA_W-1]);
         SUB, SBB, CMP: v_flag = (a[DATA_W-1] != b[DATA_W-1]) && (flag_r[DATA_W-1] != a[DATA_W-1]);
         default:       v_flag = 1'b0;
      endcase
   end
`else
   assign v_flag = 1'b0;
`endif

   always_comb begin
      flags          = '0;
      flags[FLAG_C]  = carry;
      flags[FLAG_ZF] = (flag_r == '0);
      flags[FLAG_N]  = flag_r[DATA_W-1];
      flags[FLAG_V]  = v_flag;
   end

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU top: output register with async active-low reset
// around alu_comb. Define ALU_OVERFLOW_EN to enable the V flag.
module alu
   import alu_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [2:0]        operation,
   input  logic [3:0]        flags_in,
   output logic [DATA_W-1:0] Z,
   output logic [3:0]        flags_out
);

   logic [DATA_W-1:0] z_d, z_q;
   logic [3:0]        flags_d, flags_q;
   logic              unused_flags_in;

   // Only the carry-in is consumed; the other incoming flags are don't-care.
   assign unused_flags_in = ^flags_in[3:1];

   alu_comb u_comb (
      .a      (A),
      .b      (B),
      .op     (operation),
      .cin    (flags_in[FLAG_C]),
      .result (z_d),
      .flags  (flags_d)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         z_q     <= '0;
         flags_q <= '0;
      end else begin
         z_q     <= z_d;
         flags_q <= flags_d;
      end
   end

   assign Z         = z_q;
   assign flags_out = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expectations, a monitor
// compares each registered result one cycle after issue.
module tb_alu;

`ifdef ALU_OVERFLOW_EN
   localparam logic V_EN = 1'b1;
`else
   localparam logic V_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] z;
      logic [3:0] f;
      string      name;
   } exp_t;

   logic       clock;
   logic       reset_n;
   logic [7:0] A, B;
   logic [2:0] operation;
   logic [3:0] flags_in;
   logic [7:0] Z;
   logic [3:0] flags_out;

   exp_t exp_q[$];
   bit   vld_in;
   bit   mon_v;
   int   tests;
   int   fails;

   alu dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .A         (A),
      .B         (B),
      .operation (operation),
      .flags_in  (flags_in),
      .Z         (Z),
      .flags_out (flags_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      mon_v = vld_in && reset_n;
      #1;
      if (mon_v) begin
         exp_t e;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: output Z=%02h flags=%04b with no expectation queued", Z, flags_out);
         end else begin
            e = exp_q.pop_front();
            if (Z !== e.z || flags_out !== e.f) begin
               fails++;
               $display("FAIL %s: got Z=%02h flags=%04b, expected Z=%02h flags=%04b",
                        e.name, Z, flags_out, e.z, e.f);
            end
         end
      end
   end

   // Expected flags given as {V,N,ZF,C}; V is masked when overflow is disabled.
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] fin, input logic [7:0] ez, input logic [3:0] ef,
                        input string name);
      exp_t e;
      @(negedge clock);
      operation = op;
      A         = a;
      B         = b;
      flags_in  = fin;
      vld_in    = 1'b1;
      e.z       = ez;
      e.f       = {ef[3] & V_EN, ef[2:0]};
      e.name    = name;
      exp_q.push_back(e);
   endtask

   task automatic check_direct(input string name, input logic [7:0] ez, input logic [3:0] ef);
      tests++;
      if (Z !== ez || flags_out !== ef) begin
         fails++;
         $display("FAIL %s: got Z=%02h flags=%04b, expected Z=%02h flags=%04b",
                  name, Z, flags_out, ez, ef);
      end
   endtask

   initial begin
      int wait_cycles;
      tests     = 0;
      fails     = 0;
      vld_in    = 1'b0;
      reset_n   = 1'b0;
      A         = '0;
      B         = '0;
      operation = '0;
      flags_in  = '0;
      #3;
      check_direct("reset_initial", 8'h00, 4'b0000);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      issue(3'b000, 8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011, "add_ff_01_wrap");
      issue(3'b000, 8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1100, "add_7f_01_ovf");
      issue(3'b010, 8'h00, 8'h01, 4'b0000, 8'hFF, 4'b0101, "sub_00_01_borrow");
      issue(3'b011, 8'h10, 8'h01, 4'b0001, 8'h0E, 4'b0000, "sbb_10_01_cin");
      issue(3'b001, 8'h10, 8'h01, 4'b0001, 8'h12, 4'b0000, "adc_10_01_cin");
      issue(3'b100, 8'hF0, 8'h0F, 4'b1111, 8'h00, 4'b0010, "and_f0_0f");
      issue(3'b111, 8'h05, 8'h05, 4'b0000, 8'h05, 4'b0010, "cmp_equal");
      issue(3'b101, 8'h0F, 8'hF0, 4'b0001, 8'hFF, 4'b0100, "or_0f_f0");
      issue(3'b110, 8'hAA, 8'hAA, 4'b0001, 8'h00, 4'b0010, "xor_aa_aa");
      issue(3'b010, 8'h80, 8'h01, 4'b0000, 8'h7F, 4'b1000, "sub_80_01_ovf");
      issue(3'b111, 8'h01, 8'h02, 4'b0000, 8'h01, 4'b0101, "cmp_less");
      issue(3'b001, 8'hFF, 8'h00, 4'b0001, 8'h00, 4'b0011, "adc_ff_00_cin");
      issue(3'b000, 8'h80, 8'h80, 4'b0000, 8'h00, 4'b1011, "add_80_80_ovf");
      issue(3'b011, 8'h00, 8'hFF, 4'b0001, 8'h00, 4'b0011, "sbb_00_ff_cin");
      issue(3'b001, 8'h01, 8'h01, 4'b1110, 8'h02, 4'b0000, "adc_upper_flags_ignored");
      issue(3'b000, 8'h20, 8'h13, 4'b0001, 8'h33, 4'b0000, "add_ignores_cin");
      issue(3'b010, 8'h05, 8'h03, 4'b0001, 8'h02, 4'b0000, "sub_ignores_cin");
      issue(3'b000, 8'h12, 8'h34, 4'b0000, 8'h46, 4'b0000, "add_before_reset");
      @(negedge clock);
      vld_in = 1'b0;
      repeat (2) @(negedge clock);

      // Reset lands mid-cycle with a new operation already presented.
      issue(3'b010, 8'h00, 8'h01, 4'b0000, 8'hFF, 4'b0101, "sub_discarded");
      #2;
      reset_n = 1'b0;
      vld_in  = 1'b0;
      exp_q.delete();
      #1;
      check_direct("reset_async_immediate", 8'h00, 4'b0000);
      @(posedge clock);
      #1;
      check_direct("reset_inflight_discarded", 8'h00, 4'b0000);
      @(negedge clock);
      reset_n = 1'b1;
      operation = 3'b000;
      A         = 8'h01;
      B         = 8'h02;
      flags_in  = 4'b0000;
      vld_in    = 1'b1;
      begin
         exp_t e;
         e.z = 8'h03; e.f = 4'b0000; e.name = "add_first_after_reset";
         exp_q.push_back(e);
      end
      issue(3'b111, 8'h00, 8'h80, 4'b0000, 8'h00, 4'b1101, "cmp_00_80_ovf");
      @(negedge clock);
      vld_in = 1'b0;

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(negedge clock);
         wait_cycles++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock and reset_n.
REQ-002 Ports SHALL be exactly:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- A, input, 8: operand A.
- B, input, 8: operand B.
- operation, input, 3: opcode.
- flags_in, input, 4: incoming flags; only bit 0 (carry-in) is used.
- Z, output, 8: result.
- flags_out, output, 4: result flags.
REQ-003 Flag bit order for flags_in and flags_out SHALL be [0] C carry/borrow, [1] ZF zero, [2] N negative, [3] V overflow.

Function
REQ-004 A, B, operation and flags_in SHALL be sampled on each rising clock edge.
REQ-005 Z and flags_out SHALL be registered, valid one cycle after sampling.
REQ-006 The block SHALL have no handshake and SHALL accept a new operation every cycle.
REQ-007 Opcodes SHALL be:
- 000 ADD: A+B.
- 001 ADC: A+B+Cin.
- 010 SUB: A-B.
- 011 SBB: A-B-Cin.
- 100 AND.
- 101 OR.
- 110 XOR.
- 111 CMP: flags as SUB, Z=A.
REQ-008 Arithmetic SHALL use 9-bit internal width.
REQ-009 For ADD/ADC, C SHALL be bit 8 of the sum (unsigned carry-out).
REQ-010 For SUB/SBB/CMP, C SHALL be 1 when a borrow occurs, i.e. unsigned A < B (+Cin).
REQ-011 For AND/OR/XOR, C SHALL be 0 and V SHALL be 0.
REQ-012 ZF SHALL be 1 iff the 8-bit operation result is 0x00. For CMP, ZF SHALL use the subtraction result, not Z.
REQ-013 N SHALL equal bit 7 of the operation result.
REQ-014 V SHALL signal two's-complement overflow:
- add: A[7]==B[7] and R[7]!=A[7];
- sub/CMP: A[7]!=B[7] and R[7]!=A[7].
REQ-015 Results SHALL wrap modulo 256, e.g. 0xFF+0x01 gives 0x00.
REQ-016 flags_in bits 1 to 3 SHALL be ignored.
REQ-017 An X-free opcode set SHALL be complete, with no latch or default-hold behaviour.

Reset
REQ-018 While reset_n=0, Z SHALL be 0x00 and flags_out SHALL be 4'b0000, asynchronously and immediately.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-020 The first edge after reset_n rises SHALL sample normally, and outputs SHALL be valid on the following cycle.

Configuration
REQ-021 Macro ALU_OVERFLOW_EN defined: V SHALL be computed per REQ-014.
REQ-022 Macro ALU_OVERFLOW_EN undefined: flags_out[3] SHALL be constant 0 and no overflow logic SHALL be synthesized.

Structure
REQ-023 Package alu_pkg SHALL hold:
- data width constant (8);
- opcode enum alu_op_t (ADD, ADC, SUB, SBB, AND, OR, XOR, CMP);
- flag index constants FLAG_C, FLAG_ZF, FLAG_N, FLAG_V.
REQ-024 Combinational computation SHALL live in sub-module alu_comb. The top module alu SHALL hold only the output register and reset.

Verification
REQ-025 Reset: reset_n=0 asserted mid-operation SHALL give Z=0x00 and flags_out=0000 without waiting for a clock edge.
REQ-026 ADD A=0xFF, B=0x01 SHALL give, next cycle, Z=0x00 with C=1, ZF=1, N=0, V=0.
REQ-027 ADD A=0x7F, B=0x01 SHALL give Z=0x80 with N=1; V=1 with ALU_OVERFLOW_EN defined, V=0 without it.
REQ-028 SUB A=0x00, B=0x01 SHALL give Z=0xFF with C=1, N=1, ZF=0, V=0.
REQ-029 SBB A=0x10, B=0x01, Cin=1 SHALL give Z=0x0E with C=0; ADC 0x10+0x01 with Cin=1 SHALL give Z=0x12.
REQ-030 AND A=0xF0, B=0x0F with flags_in=1111 SHALL give Z=0x00 with ZF=1 and C=0.
REQ-031 CMP A=0x05, B=0x05 SHALL give Z=0x05 with ZF=1.
